barret_251_arbiter: RTL and testbench

Shares one combinational barret_for_251 reducer (15-bit operand in, 8-bit residue out) among N_REQ requesters. Each requester uses a valid/ready handshake. A round-robin arbiter picks one requester per cycle. The block wraps the reducer in a 2-stage register pipeline with full backpressure, and returns each residue tagged with the requester id. It sits between the operand producers (multiplier/accumulator lanes) and downstream GF(251) consumers.

---
 rtl/barret_251_pkg.sv | 13 +
 rtl/barret_for_251.sv | 25 ++
 rtl/barret_251_arbiter.sv | 123 ++++++++++++
 tb/tb_barret_251_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/barret_251_pkg.sv
// Shared constants and helpers for the GF(251) Barrett reduction slice.
package barret_251_pkg;

  localparam int unsigned Q     = 251;
  localparam int unsigned IN_W  = 15;
  localparam int unsigned OUT_W = 8;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/barret_for_251.sv
// Combinational Barrett reduction of a 15-bit operand modulo 251.
module barret_for_251
  import barret_251_pkg::*;
(
  input  logic [IN_W-1:0]  din_a,
  output logic [OUT_W-1:0] dout_r
);

  // m = floor(2^23 / 251); for operands below 2^15 the quotient estimate
  // is at most one short, so a single conditional subtract finishes it.
  localparam int unsigned K = 23;
  localparam int unsigned M = (32'd1 << K) / Q;

  logic [7:0]      q_est;
  logic [IN_W-1:0] qm;
  logic [IN_W-1:0] r_raw;

  always_comb begin
    q_est  = 8'((32'(din_a) * M) >> K);
    qm     = IN_W'(32'(q_est) * Q);
    r_raw  = din_a - qm;
    dout_r = (r_raw >= IN_W'(Q)) ? OUT_W'(r_raw - IN_W'(Q)) : OUT_W'(r_raw);
  end

endmodule

// File: rtl/barret_251_arbiter.sv
// Round-robin sharing of one mod-251 reducer among N_REQ requesters,
// wrapped in a two-stage valid/ready pipeline with id-tagged responses.
module barret_251_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IN_W  = barret_251_pkg::IN_W,
  parameter int unsigned OUT_W = barret_251_pkg::OUT_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_REQ-1:0]                         req_valid,
  input  logic [N_REQ*IN_W-1:0]                    req_data,
  output logic [N_REQ-1:0]                         req_ready,
  output logic                                     rsp_valid,
  output logic [OUT_W-1:0]                         rsp_data,
  output logic [barret_251_pkg::id_w(N_REQ)-1:0]   rsp_id,
  input  logic                                     rsp_ready,
  output logic [CNT_W-1:0]                         ops_count
);
  import barret_251_pkg::*;

  localparam int unsigned ID_W = id_w(N_REQ);

  logic              s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]   s1_data_q,  s1_data_d;
  logic [ID_W-1:0]   s1_id_q,    s1_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [OUT_W-1:0]  rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]  ops_cnt_q,   ops_cnt_d;

  logic [ID_W-1:0]   grant;
  logic              grant_found;
  int unsigned       idx;
  logic              s2_load;
  logic              s1_free;
  logic              accept;
  logic [OUT_W-1:0]  red_r;

  barret_for_251 u_reducer (
    .din_a  (s1_data_q),
    .dout_r (red_r)
  );

  // Search order starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant       = ID_W'(idx);
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    s2_load   = s1_valid_q & (~rsp_valid_q | rsp_ready);
    s1_free   = ~s1_valid_q | s2_load;
    accept    = s1_free & grant_found;
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_id_d    = s1_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = req_data[grant*IN_W +: IN_W];
      s1_id_d    = grant;
      rr_ptr_d   = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (s2_load) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = red_r;
      rsp_id_d    = s1_id_q;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    ops_cnt_d = ops_cnt_q + CNT_W'(rsp_valid_q & rsp_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
      ops_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
      ops_cnt_q   <= ops_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign ops_count = ops_cnt_q;

endmodule

// File: tb/tb_barret_251_arbiter.sv
// Scoreboard bench for barret_251_arbiter: requester driver, response monitor
// and directed scenarios with hand-computed residues.
module tb_barret_251_arbiter;

  localparam int N    = 4;
  localparam int IN_W = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*IN_W-1:0] req_data;
  logic [N-1:0]    req_ready, req_ready4;
  logic            rsp_valid, rsp_valid4;
  logic [7:0]      rsp_data, rsp_data4;
  logic [1:0]      rsp_id, rsp_id4;
  logic            rsp_ready = 1'b1;
  logic [15:0]     ops_count;
  logic [3:0]      ops_count4;

  barret_251_arbiter #(.N_REQ(N), .IN_W(IN_W), .OUT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .ops_count(ops_count)
  );

  barret_251_arbiter #(.N_REQ(N), .IN_W(IN_W), .OUT_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready4), .rsp_valid(rsp_valid4), .rsp_data(rsp_data4),
    .rsp_id(rsp_id4), .rsp_ready(rsp_ready), .ops_count(ops_count4)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int data; } exp_t;

  exp_t        exp_q[$];
  int unsigned req_q[N][$];
  int unsigned rsp_cycles[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          acc_count = 0;
  int unsigned last_acc_cyc = 0;
  logic [N-1:0] hs = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_rsp(input int id, input int data);
    exp_t e;
    e.id = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  function automatic bit busy();
    bit b = (exp_q.size() != 0);
    for (int i = 0; i < N; i++) if (req_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name);
    for (int c = 0; c < 300 && busy(); c++) step();
    check(name, int'(busy()), 0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) req_q[i].delete();
    step();
    rst = 1'b0;
    step();
  endtask

  // Requester driver: presents queue heads, retires them on handshake.
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (hs[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
      for (int i = 0; i < N; i++) begin
        if (req_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[i*IN_W +: IN_W] = 15'(req_q[i][0]);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      #4;
      hs = rst ? '0 : (req_valid & req_ready);
      if (hs != '0) begin
        acc_count += $countones(hs);
        last_acc_cyc = cyc;
      end
      if (!rst)
        check("ready_onehot_valid",
              int'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 1);
    end
  end

  // Response monitor: pops the scoreboard on every completed response.
  initial begin : monitor
    logic       stall_prev;
    logic [7:0] hold_data;
    logic [1:0] hold_id;
    exp_t       e;
    stall_prev = 1'b0;
    hold_data  = '0;
    hold_id    = '0;
    forever begin
      @(negedge clk);
      #4;
      if (stall_prev && !rst) begin
        check("hold_valid", int'(rsp_valid), 1);
        check("hold_data", int'(rsp_data), int'(hold_data));
        check("hold_id", int'(rsp_id), int'(hold_id));
      end
      stall_prev = !rst && rsp_valid && !rsp_ready;
      hold_data  = rsp_data;
      hold_id    = rsp_id;
      if (!rst && rsp_valid && rsp_ready) begin
        rsp_cycles.push_back(cyc);
        check("rsp_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rsp_id", int'(rsp_id), e.id);
          check("rsp_data", int'(rsp_data), e.data);
        end
      end
    end
  end

  initial begin
    // 1: reset state, single operand, latency
    do_reset();
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_ops_count", int'(ops_count), 0);
    check("rst_req_ready", int'(req_ready), 0);
    rsp_ready = 1'b1;
    rsp_cycles.delete();
    req_q[0].push_back(300);
    expect_rsp(0, 49);
    drain("t1_drain");
    check("t1_nrsp", rsp_cycles.size(), 1);
    if (rsp_cycles.size() >= 1)
      check("t1_latency", int'(rsp_cycles[0] - last_acc_cyc), 2);
    check("t1_ops_count", int'(ops_count), 1);

    // 2: boundary operands from requester 2, back to back
    rsp_cycles.delete();
    req_q[2].push_back(250);   expect_rsp(2, 250);
    req_q[2].push_back(251);   expect_rsp(2, 0);
    req_q[2].push_back(502);   expect_rsp(2, 0);
    req_q[2].push_back(32767); expect_rsp(2, 137);
    drain("t2_drain");
    check("t2_nrsp", rsp_cycles.size(), 4);
    if (rsp_cycles.size() == 4)
      check("t2_span", int'(rsp_cycles[3] - rsp_cycles[0]), 3);
    check("t2_ops_count", int'(ops_count), 5);

    // 3: all requesters busy -> round-robin order
    do_reset();
    rsp_cycles.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        req_q[i].push_back(1000 + i);
        expect_rsp(i, 247 + i);
      end
    drain("t3_drain");
    check("t3_nrsp", rsp_cycles.size(), 8);
    if (rsp_cycles.size() == 8)
      check("t3_span", int'(rsp_cycles[7] - rsp_cycles[0]), 7);

    // 4: backpressure, two operands in flight then stall
    rsp_ready = 1'b0;
    acc_count = 0;
    for (int i = 0; i < N; i++) begin
      req_q[i].push_back(2000 + i);
      expect_rsp(i, 243 + i);
    end
    repeat (5) step();
    check("t4_accepts", acc_count, 2);
    check("t4_req_ready", int'(req_ready), 0);
    check("t4_rsp_valid", int'(rsp_valid), 1);
    rsp_ready = 1'b1;
    drain("t4_drain");
    check("t4_total_accepts", acc_count, 4);

    // 5: reset with two operands in flight
    rsp_ready = 1'b0;
    acc_count = 0;
    req_q[1].push_back(5000);
    req_q[2].push_back(6000);
    repeat (4) step();
    check("t5_inflight", acc_count, 2);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    check("t5_rsp_valid", int'(rsp_valid), 0);
    check("t5_ops_count", int'(ops_count), 0);
    rsp_ready = 1'b1;
    req_q[3].push_back(700);
    req_q[1].push_back(800);
    expect_rsp(1, 47);
    expect_rsp(3, 198);
    drain("t5_drain");

    // 6: counter wrap on the CNT_W=4 instance
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      req_q[1].push_back(252 * k);
      expect_rsp(1, k);
    end
    drain("t6_drain");
    check("t6_ops_count16", int'(ops_count), 17);
    check("t6_ops_count4", int'(ops_count4), 1);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
